fb_wr_ctrl: RTL and testbench

FB_WR_CTRL -- requirements
Module: fb_wr_ctrl

---
 rtl/fb_wr_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_fb_wr_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_wr_ctrl.sv
// Frame-buffer write controller: moves pixel words from an upstream FWFT FIFO into
// fixed-length memory write bursts, rotating over BUF_NUM frame buffers.
module fb_wr_ctrl #(
  parameter int          DW           = 32,
  parameter int          AW           = 32,
  parameter int          BURST_LEN    = 64,
  parameter int          FRAME_BURSTS = 32400,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter logic [31:0] BUF_STRIDE   = 32'h0080_0000,
  parameter int          BUF_NUM      = 3
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          fs_i,
  input  logic [11:0]   fifo_cnt_i,
  input  logic [DW-1:0] fifo_data_i,
  output logic          fifo_rd_o,
  output logic          wr_req_o,
  output logic [AW-1:0] wr_addr_o,
  input  logic          wr_ack_i,
  output logic [DW-1:0] wr_data_o,
  output logic          wr_valid_o,
  input  logic          wr_ready_i,
  output logic [1:0]    buf_idx_o,
  output logic [1:0]    rd_buf_o,
  output logic          frame_done_o,
  output logic          frame_abort_o
);

  localparam int              BCW        = $clog2(BURST_LEN);
  localparam int              FCW        = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam logic [BCW-1:0]  BEAT_LAST  = BCW'(BURST_LEN - 1);
  localparam logic [FCW-1:0]  BURST_LAST = FCW'(FRAME_BURSTS - 1);
  localparam logic [AW-1:0]   ADDR_INC   = AW'(BURST_LEN * DW / 8);
  localparam logic [AW-1:0]   BASE_A     = AW'(BASE_ADDR);
  localparam logic [AW-1:0]   STRIDE_A   = AW'(BUF_STRIDE);
  localparam logic [1:0]      IDX_LAST   = 2'(BUF_NUM - 1);
  localparam logic [12:0]     BL_THR     = 13'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_REQ       = 3'd2,
    S_BURST     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [BCW-1:0]  beat_q, beat_d;
  logic [FCW-1:0]  burst_q, burst_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [1:0]      buf_idx_q, buf_idx_d;
  logic [1:0]      rd_buf_q, rd_buf_d;
  logic            pend_q, pend_d;
  logic            abort_q, abort_d;
  logic            beat_fire_s;
  logic [1:0]      buf_next_s;

  // Buffer base address, wrapping modulo 2^AW.
  function automatic logic [AW-1:0] frame_base(input logic [1:0] idx);
    case (idx)
      2'd0:    frame_base = BASE_A;
      2'd1:    frame_base = BASE_A + STRIDE_A;
      2'd2:    frame_base = BASE_A + (STRIDE_A << 1);
      default: frame_base = BASE_A + (STRIDE_A << 1) + STRIDE_A;
    endcase
  endfunction

  assign beat_fire_s = (state_q == S_BURST) && wr_ready_i;
  assign buf_next_s  = (buf_idx_q == IDX_LAST) ? 2'd0 : buf_idx_q + 2'd1;

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    burst_d   = burst_q;
    addr_d    = addr_q;
    buf_idx_d = buf_idx_q;
    rd_buf_d  = rd_buf_q;
    pend_d    = pend_q;
    abort_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fs_i) begin
          state_d = S_WAIT_DATA;
          burst_d = '0;
          addr_d  = frame_base(buf_idx_q);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_DATA: begin
        if (fs_i) begin
          abort_d = 1'b1;
          burst_d = '0;
          addr_d  = frame_base(buf_idx_q);
        end else if ({1'b0, fifo_cnt_i} >= BL_THR) begin
          state_d = S_REQ;
        end else begin
          state_d = S_WAIT_DATA;
        end
      end
      S_REQ: begin
        pend_d = pend_q | fs_i;
        if (wr_ack_i) begin
          state_d = S_BURST;
          beat_d  = '0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_BURST: begin
        if (beat_fire_s && (beat_q == BEAT_LAST)) begin
          beat_d = '0;
          // A frame start during the final beat of the last burst still completes the frame.
          if (pend_q || (fs_i && (burst_q != BURST_LAST))) begin
            state_d = S_WAIT_DATA;
            abort_d = 1'b1;
            burst_d = '0;
            addr_d  = frame_base(buf_idx_q);
            pend_d  = 1'b0;
          end else if (burst_q == BURST_LAST) begin
            state_d = S_DONE;
            pend_d  = fs_i;
          end else begin
            state_d = S_WAIT_DATA;
            burst_d = burst_q + FCW'(1);
            addr_d  = addr_q + ADDR_INC;
            pend_d  = 1'b0;
          end
        end else if (beat_fire_s) begin
          beat_d = beat_q + BCW'(1);
          pend_d = pend_q | fs_i;
        end else begin
          pend_d = pend_q | fs_i;
        end
      end
      S_DONE: begin
        rd_buf_d  = buf_idx_q;
        buf_idx_d = buf_next_s;
        burst_d   = '0;
        pend_d    = 1'b0;
        if (fs_i || pend_q) begin
          state_d = S_WAIT_DATA;
          addr_d  = frame_base(buf_next_s);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      burst_q   <= '0;
      addr_q    <= BASE_A;
      buf_idx_q <= 2'd0;
      rd_buf_q  <= 2'd0;
      pend_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      addr_q    <= addr_d;
      buf_idx_q <= buf_idx_d;
      rd_buf_q  <= rd_buf_d;
      pend_q    <= pend_d;
      abort_q   <= abort_d;
    end
  end

  assign wr_req_o      = (state_q == S_REQ);
  assign wr_valid_o    = (state_q == S_BURST);
  assign fifo_rd_o     = wr_valid_o & wr_ready_i;
  assign wr_data_o     = fifo_data_i;
  assign wr_addr_o     = addr_q;
  assign buf_idx_o     = buf_idx_q;
  assign rd_buf_o      = rd_buf_q;
  assign frame_done_o  = (state_q == S_DONE);
  assign frame_abort_o = abort_q;

endmodule

// File: tb/tb_fb_wr_ctrl.sv
// Directed self-checking bench for fb_wr_ctrl with BURST_LEN=4, FRAME_BURSTS=3.
module tb_fb_wr_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        fs_i = 1'b0;
  logic [11:0] fifo_cnt_i = 12'd100;
  logic [31:0] fifo_data_i = 32'd0;
  logic        fifo_rd_o;
  logic        wr_req_o;
  logic [31:0] wr_addr_o;
  logic        wr_ack_i = 1'b0;
  logic [31:0] wr_data_o;
  logic        wr_valid_o;
  logic        wr_ready_i = 1'b1;
  logic [1:0]  buf_idx_o;
  logic [1:0]  rd_buf_o;
  logic        frame_done_o;
  logic        frame_abort_o;

  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic ack_en = 1'b1;
  logic [31:0] req_addrs[$];
  logic [31:0] beats[$];

  fb_wr_ctrl #(.DW(32), .AW(32), .BURST_LEN(4), .FRAME_BURSTS(3),
               .BASE_ADDR(32'h1000_0000), .BUF_STRIDE(32'h0080_0000), .BUF_NUM(3)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .fs_i(fs_i), .fifo_cnt_i(fifo_cnt_i),
    .fifo_data_i(fifo_data_i), .fifo_rd_o(fifo_rd_o), .wr_req_o(wr_req_o),
    .wr_addr_o(wr_addr_o), .wr_ack_i(wr_ack_i), .wr_data_o(wr_data_o),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .buf_idx_o(buf_idx_o),
    .rd_buf_o(rd_buf_o), .frame_done_o(frame_done_o), .frame_abort_o(frame_abort_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: acknowledge requests, log handshakes, advance the FIFO head on a pop.
  task automatic tick();
    logic pop;
    wr_ack_i = ack_en & wr_req_o;
    #1;
    if (wr_req_o && wr_ack_i) req_addrs.push_back(wr_addr_o);
    pop = fifo_rd_o;
    if (pop) beats.push_back(wr_data_o);
    if (frame_done_o) done_cnt++;
    if (frame_abort_o) abort_cnt++;
    @(posedge clk_i);
    #1;
    if (pop) fifo_data_i = fifo_data_i + 32'd1;
  endtask

  task automatic pulse_fs();
    fs_i = 1'b1;
    tick();
    fs_i = 1'b0;
  endtask

  task automatic run_frame();
    for (int i = 0; i < 200 && !frame_done_o; i++) tick();
    check("frame_done_reached", {31'd0, frame_done_o}, 32'd1);
    tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   {31'd0, wr_req_o},      32'd0);
    check({tag, "_valid"}, {31'd0, wr_valid_o},    32'd0);
    check({tag, "_rd"},    {31'd0, fifo_rd_o},     32'd0);
    check({tag, "_done"},  {31'd0, frame_done_o},  32'd0);
    check({tag, "_abort"}, {31'd0, frame_abort_o}, 32'd0);
    check({tag, "_buf"},   {30'd0, buf_idx_o},     32'd0);
    check({tag, "_rdbuf"}, {30'd0, rd_buf_o},      32'd0);
    check({tag, "_addr"},  wr_addr_o,              32'h1000_0000);
  endtask

  initial begin
    int b0;
    int ok;
    int req_cycles;
    logic [31:0] d0;

    // Reset values
    repeat (3) tick();
    check_reset("rst");
    rst_n_i = 1'b1;
    tick();

    // Single frame, full FIFO, immediate ack and ready
    req_addrs.delete(); beats.delete();
    pulse_fs();
    run_frame();
    check("f1_nreq", req_addrs.size(), 32'd3);
    check("f1_addr0", req_addrs[0], 32'h1000_0000);
    check("f1_addr1", req_addrs[1], 32'h1000_0010);
    check("f1_addr2", req_addrs[2], 32'h1000_0020);
    check("f1_pops", beats.size(), 32'd12);
    ok = 1;
    foreach (beats[i]) if (beats[i] !== 32'(i)) ok = 0;
    check("f1_order", ok, 32'd1);
    check("f1_done_cnt", done_cnt, 32'd1);
    check("f1_rdbuf", {30'd0, rd_buf_o}, 32'd0);
    check("f1_buf", {30'd0, buf_idx_o}, 32'd1);
    check("f1_done_pulse", {31'd0, frame_done_o}, 32'd0);

    // Buffer rotation over three more frames
    req_addrs.delete();
    pulse_fs(); run_frame();
    check("f2_base", req_addrs[0], 32'h1080_0000);
    check("f2_addr1", req_addrs[1], 32'h1080_0010);
    req_addrs.delete();
    pulse_fs(); run_frame();
    check("f3_base", req_addrs[0], 32'h1100_0000);
    check("f3_rdbuf", {30'd0, rd_buf_o}, 32'd2);
    check("f3_buf_wrap", {30'd0, buf_idx_o}, 32'd0);
    req_addrs.delete();
    pulse_fs(); run_frame();
    check("f4_base", req_addrs[0], 32'h1000_0000);
    check("f4_done_cnt", done_cnt, 32'd4);

    // FIFO threshold: 3 words holds, 4 words requests
    fifo_cnt_i = 12'd3;
    pulse_fs();
    req_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wr_req_o) req_cycles++;
    end
    check("thr_no_req", req_cycles, 32'd0);
    fifo_cnt_i = 12'd4;
    tick();
    check("thr_req", {31'd0, wr_req_o}, 32'd1);
    check("thr_addr", wr_addr_o, 32'h1080_0000);
    fifo_cnt_i = 12'd100;

    // Ready toggling 1,0,1,... inside a burst
    wr_ready_i = 1'b1;
    tick();
    check("stall_in_burst", {31'd0, wr_valid_o}, 32'd1);
    b0 = beats.size();
    d0 = fifo_data_i;
    for (int k = 0; k < 8; k++) begin
      wr_ready_i = (k % 2 == 0);
      #1;
      if (k == 1) begin
        check("stall_rd", {31'd0, fifo_rd_o}, 32'd0);
        check("stall_valid", {31'd0, wr_valid_o}, 32'd1);
        check("stall_data", wr_data_o, d0 + 32'd1);
      end
      tick();
    end
    wr_ready_i = 1'b1;
    check("stall_pops", beats.size() - b0, 32'd4);
    ok = 1;
    for (int j = 0; j < 4; j++) if (beats[b0 + j] !== d0 + 32'(j)) ok = 0;
    check("stall_order", ok, 32'd1);
    check("stall_exit", {31'd0, wr_valid_o}, 32'd0);
    run_frame();
    check("f5_buf", {30'd0, buf_idx_o}, 32'd2);

    // Frame start during the second burst
    req_addrs.delete();
    b0 = beats.size();
    pulse_fs();
    for (int i = 0; i < 50 && req_addrs.size() < 2; i++) tick();
    check("ab_second_req", req_addrs.size(), 32'd2);
    check("ab_in_burst", {31'd0, wr_valid_o}, 32'd1);
    pulse_fs();
    for (int i = 0; i < 50 && !frame_abort_o; i++) tick();
    check("ab_pulse", {31'd0, frame_abort_o}, 32'd1);
    check("ab_beats", beats.size() - b0, 32'd8);
    check("ab_addr", wr_addr_o, 32'h1100_0000);
    check("ab_buf", {30'd0, buf_idx_o}, 32'd2);
    check("ab_no_done", done_cnt, 32'd5);
    tick();
    check("ab_pulse_end", {31'd0, frame_abort_o}, 32'd0);
    for (int i = 0; i < 50 && req_addrs.size() < 3; i++) tick();
    check("ab_restart_addr", req_addrs[2], 32'h1100_0000);

    // Reset in the middle of a burst
    tick();
    check("mid_in_burst", {31'd0, wr_valid_o}, 32'd1);
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    check_reset("mid");
    req_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr_req_o) req_cycles++;
    end
    check("mid_no_req", req_cycles, 32'd0);

    // Frame after reset, with a frame start arriving in DONE
    req_addrs.delete();
    abort_cnt = 0;
    pulse_fs();
    for (int i = 0; i < 200 && !frame_done_o; i++) tick();
    check("fsd_done", {31'd0, frame_done_o}, 32'd1);
    check("fsd_base", req_addrs[0], 32'h1000_0000);
    pulse_fs();
    check("fsd_no_abort", {31'd0, frame_abort_o}, 32'd0);
    check("fsd_buf", {30'd0, buf_idx_o}, 32'd1);
    check("fsd_rdbuf", {30'd0, rd_buf_o}, 32'd0);
    check("fsd_addr", wr_addr_o, 32'h1080_0000);
    tick();
    check("fsd_req", {31'd0, wr_req_o}, 32'd1);
    check("fsd_abort_cnt", abort_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
